// File: rtl/result_streamer.sv
// AXI-Stream master that serializes a DATA_SIZE x DATA_SIZE result map into
// BUS_WIDTH-bit beats, MSB-first, with zero padding leading the first beat.
module result_streamer #(
  parameter int DATA_SIZE  = 16,
  parameter int ELEM_WIDTH = 8,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [DATA_SIZE*DATA_SIZE*ELEM_WIDTH-1:0] data_in,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  output logic [BUS_WIDTH-1:0]                      m_axis_tdata,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast
);

  localparam int REQUIRED_BITS = DATA_SIZE * DATA_SIZE * ELEM_WIDTH;
  localparam int NUM_TRANSFERS = (REQUIRED_BITS + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int PADDED_SIZE   = NUM_TRANSFERS * BUS_WIDTH;
  localparam int CNT_W         = $clog2(NUM_TRANSFERS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_TRANSFERS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                 state, state_nxt;
  logic [PADDED_SIZE-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]       beat_cnt, cnt_nxt;
  logic                   done_nxt;
  logic                   handshake;
  logic                   last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      beat_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      beat_cnt  <= cnt_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    busy          = (state == SEND);
    m_axis_tvalid = (state == SEND);
    last_beat     = (beat_cnt == LAST_BEAT);
    m_axis_tlast  = (state == SEND) && last_beat;
    m_axis_tdata  = shift_reg[PADDED_SIZE-1 -: BUS_WIDTH];
    handshake     = m_axis_tvalid && m_axis_tready;
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = beat_cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          // zero-extension places the padding above data_in, so it leads the first beat
          shift_nxt = PADDED_SIZE'(data_in);
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          shift_nxt = shift_reg << BUS_WIDTH;
          if (last_beat) begin
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
